// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator (SLL, SRL, SRA, ROL, ROR).
// The log2(XLEN) barrel levels are distributed over PIPE register stages.
// Valid/ready handshakes sit on both sides, and a sideband tag passes through unchanged.
//
// Ports:
//   CLK, rst_n         clock, asynchronous active-low reset
//   flush              synchronous squash of every in-flight operation
//   in_valid/in_ready  request handshake (op, rs1, shamt, tag_in)
//   out_valid/out_ready result handshake (result, tag_out, illegal)
//   op                 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   illegal            qualifies out_valid; result is 0 for an illegal op
module shift_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PIPE  = 2,
   parameter int unsigned TAG_W = 5,
   localparam int unsigned SH_W = $clog2(XLEN)
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [SH_W-1:0]  shamt,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out,
   output logic             illegal
);

   localparam logic [2:0] OpSll = 3'b000;
   localparam logic [2:0] OpSra = 3'b010;
   localparam logic [2:0] OpRol = 3'b011;
   localparam logic [2:0] OpRor = 3'b100;

   function automatic logic is_left(input logic [2:0] o);
      return (o == OpSll) || (o == OpRol);
   endfunction

   function automatic logic is_illegal(input logic [2:0] o);
      return o > OpRor;
   endfunction

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
      return {<<{d}};
   endfunction

   // One right-shift level. Rotates wrap the shifted-out bits back in at the top.
   // Left ops arrive here bit-reversed, so a right rotate serves both directions.
   function automatic logic [XLEN-1:0] shr_level(input logic [XLEN-1:0] d,
                                                 input int unsigned   amt,
                                                 input logic [2:0]    o);
      logic [XLEN-1:0] fill;
      if (o == OpRol || o == OpRor) begin
         fill = d;
      end else if (o == OpSra) begin
         fill = {XLEN{d[XLEN-1]}};
      end else begin
         fill = '0;
      end
      return XLEN'({fill, d} >> amt);
   endfunction

   logic adv;
   logic last_valid;

   // The whole pipe moves as one; it stalls only when the last slot is held.
   assign adv      = !last_valid || out_ready;
   assign in_ready = adv;

   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      // Stage s owns levels k with floor(k*PIPE/SH_W) == s, i.e. k in [Lo, Hi).
      localparam int unsigned Lo = (s * SH_W + PIPE - 1) / PIPE;
      localparam int unsigned Hi = ((s + 1) * SH_W + PIPE - 1) / PIPE;

      logic             v_in;
      logic [XLEN-1:0]  d_in;
      logic [XLEN-1:0]  d_out;
      logic [2:0]       o_in;
      logic [TAG_W-1:0] t_in;
      logic [SH_W-1:Lo] sh_in;
      logic [XLEN-1:0]  lvl [Lo:Hi];

      logic             valid_q;
      logic [XLEN-1:0]  data_q;
      logic [2:0]       op_q;
      logic [TAG_W-1:0] tag_q;

      if (s == 0) begin : g_entry
         assign v_in  = in_valid;
         assign d_in  = is_left(op) ? bit_rev(rs1) : rs1;
         assign o_in  = op;
         assign t_in  = tag_in;
         assign sh_in = shamt;
      end else begin : g_link
         assign v_in  = g_stage[s-1].valid_q;
         assign d_in  = g_stage[s-1].data_q;
         assign o_in  = g_stage[s-1].op_q;
         assign t_in  = g_stage[s-1].tag_q;
         assign sh_in = g_stage[s-1].g_rem.rem_q;
      end

      assign lvl[Lo] = d_in;
      for (genvar k = Lo; k < Hi; k++) begin : g_level
         assign lvl[k+1] = sh_in[k] ? shr_level(lvl[k], 1 << k, o_in) : lvl[k];
      end

      if (s == PIPE - 1) begin : g_exit
         assign d_out = is_illegal(o_in) ? '0 :
                        (is_left(o_in) ? bit_rev(lvl[Hi]) : lvl[Hi]);
      end else begin : g_rem
         // Only the shift-amount bits of later levels travel on.
         logic [SH_W-1:Hi] rem_q;

         assign d_out = lvl[Hi];

         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
               rem_q <= '0;
            end else if (adv) begin
               rem_q <= sh_in[SH_W-1:Hi];
            end
         end
      end

      always_ff @(posedge CLK or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            tag_q   <= '0;
         end else begin
            // A flush also drops whatever in_valid offers in the same cycle.
            if (flush) begin
               valid_q <= 1'b0;
            end else if (adv) begin
               valid_q <= v_in;
            end
            if (adv) begin
               data_q <= d_out;
               op_q   <= o_in;
               tag_q  <= t_in;
            end
         end
      end
   end

   assign last_valid = g_stage[PIPE-1].valid_q;
   assign out_valid  = last_valid;
   assign result     = g_stage[PIPE-1].data_q;
   assign tag_out    = g_stage[PIPE-1].tag_q;
   assign illegal    = is_illegal(g_stage[PIPE-1].op_q);

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined successor to the integer ALU's combinational shift unit.
- Performs SLL/SRL/SRA plus rotate-left/rotate-right (Zbb ROL/ROR) on XLEN-bit operands.
- Spreads the log2(XLEN) barrel levels across PIPE register stages, with a valid/ready handshake on both sides and a result tag that passes through unchanged.
- Sits between the issue stage and the writeback arbiter.

Parameters:
- XLEN, 32, operand width; power of two, 32 or 64.
- PIPE, 2, register stages; 1..log2(XLEN). Latency equals PIPE cycles.
- TAG_W, 5, sideband tag width (destination register index).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all in-flight operations.
- in_valid  input  1  request valid.
- in_ready  output  1  the block accepts a request this cycle.
- op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101..111 are illegal.
- rs1  input  XLEN  operand.
- shamt  input  log2(XLEN)  shift amount; used as-is, no further masking.
- tag_in  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  XLEN  shifted or rotated value.
- tag_out  output  TAG_W  tag_in of the same request.
- illegal  output  1  qualifies out_valid; set when op was 101..111.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0, result=0, tag_out=0, illegal=0. in_ready becomes 1 once reset is released.
- Datapath, left ops (SLL, ROL):
  - Operand is bit-reversed on entry, processed as a right operation, and bit-reversed on exit.
  - Fill value is 0 for logical ops. For rotates, the bits shifted out are wrapped back in at each level.
- Datapath, SRA: fill value is rs1[XLEN-1].
- Level distribution:
  - Level k (k=0..log2(XLEN)-1) shifts by 2^k when shamt[k]=1.
  - Level k is placed in stage floor(k*PIPE/log2(XLEN)).
  - Every stage output is registered, and result is the last-stage register.
- Each stage register holds: valid, partial data, remaining shamt bits, op, tag. The result is never recomputed from the current inputs.
- Handshake:
  - adv = !v_last || out_ready; in_ready = adv.
  - When adv=1, every stage shifts forward one slot, and a bubble enters if in_valid=0.
  - When adv=0, all stages hold.
  - A request transfers on in_valid && in_ready. A result transfers on out_valid && out_ready.
  - out_valid, result, tag_out and illegal stay stable while out_valid=1 and out_ready=0.
- Throughput: one operation per cycle when out_ready is held high. Latency is exactly PIPE cycles from acceptance to out_valid.
- Illegal op: the request flows through with full latency; result=0, illegal=1. It is never dropped.
- shamt=0: result equals rs1 for all legal ops.
- Rotate by XLEN-1: ROL equals ROR by 1, and the reverse holds.
- flush:
  - Clears all valid bits on the next edge; out_valid=0 the following cycle.
  - in_valid in the flush cycle is ignored and the request is not accepted.
  - Data registers may keep stale values.
- Reset mid-operation: in-flight operations are discarded with no output pulse.
- Backpressure with a full pipe: inputs are ignored while in_ready=0, and the bench must not see a request lost or duplicated.

Test Plan:
- Directed ops:
  - XLEN=32, PIPE=2. rs1=0x8000_00F1, shamt=4.
  - Expected results: SLL->0x0000_0F10, SRL->0x0800_000F, SRA->0xF800_000F, ROL->0x0000_0F18, ROR->0x1800_000F.
  - out_valid rises exactly 2 cycles after acceptance.
- Edge amounts:
  - rs1=0xDEAD_BEEF, shamt=0 -> result 0xDEAD_BEEF for all five ops.
  - SRA with rs1=0x8000_0000, shamt=31 -> 0xFFFF_FFFF.
  - ROL with shamt=31 gives the same result as ROR with shamt=1.
- Backpressure:
  - Stream 6 requests with tags 1..6 back-to-back; hold out_ready=0 for cycles 3..7.
  - Expected: in_ready=0 while the pipe is full, outputs stay stable, tags emerge in order 1..6 with none lost or duplicated.
- Flush and reset:
  - Two requests in flight, assert flush for one cycle -> no out_valid follows, and in_ready=1 the next cycle.
  - Repeat with rst_n pulsed low mid-cycle -> outputs go to 0 immediately.
- Illegal op: op=110 with tag 0x1A -> after PIPE cycles, out_valid=1, illegal=1, result=0, tag_out=0x1A.
- Parameter sweep:
  - XLEN=64 with PIPE=1, 3 and 6. Run 10k random op/rs1/shamt with random out_ready, checked against a reference model.
  - Measured latency must equal PIPE.
